// File: rtl/fp_div_pkg.sv
// rtl/fp_div_pkg.sv - shared types and helpers for the sequential FP divider
// Widths are passed as arguments so one package serves every EXP_W/MANT_W instance.
package fp_div_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SPECIAL,
      S_DIV,
      S_NORM,
      S_ROUND
   } state_e;

   typedef enum logic [1:0] {
      CLS_ZERO,
      CLS_NORMAL,
      CLS_INF,
      CLS_NAN
   } op_class_e;

   localparam int MAX_W = 128;

   // Quiet NaN: sign 0, exponent all ones, fraction MSB set; caller keeps the low bits.
   function automatic logic [MAX_W-1:0] fp_qnan(input int exp_w, input int mant_w);
      logic [MAX_W-1:0] v;
      v = ((MAX_W'(1) << exp_w) - MAX_W'(1)) << mant_w;
      v = v | (MAX_W'(1) << (mant_w - 1));
      return v;
   endfunction

   // Subnormals (exp=0) are classed as zero.
   function automatic op_class_e fp_classify(input logic [63:0]      exp_f,
                                             input logic [MAX_W-1:0] frac_f,
                                             input int               exp_w);
      logic [63:0] ones;
      op_class_e   c;
      ones = (64'd1 << exp_w) - 64'd1;
      if (exp_f == 64'd0) begin
         c = CLS_ZERO;
      end else if (exp_f == ones) begin
         c = (frac_f == '0) ? CLS_INF : CLS_NAN;
      end else begin
         c = CLS_NORMAL;
      end
      return c;
   endfunction

endpackage

// File: rtl/fp_mant_div_iter.sv
// rtl/fp_mant_div_iter.sv - restoring bit-serial mantissa divider
// done_o is high during the final step so the caller can leave on that same edge.
module fp_mant_div_iter
   import fp_div_pkg::*;
#(
   parameter int MANT_W = 23
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic              step_i,
   input  logic [MANT_W:0]   a_mant_i,
   input  logic [MANT_W:0]   b_mant_i,
   output logic              done_o,
   output logic [MANT_W+3:0] q_o,
   output logic [MANT_W+1:0] rem_o
);

   localparam int QW = MANT_W + 4;
   localparam int CW = $clog2(QW + 1);
   localparam logic [CW-1:0] LAST = CW'(QW - 1);

   logic [MANT_W+1:0] rem_q, rem_d, rem_sub;
   logic [MANT_W:0]   div_q, div_d;
   logic [QW-1:0]     q_q, q_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              ge;

   assign ge      = rem_q >= {1'b0, div_q};
   assign rem_sub = ge ? (rem_q - {1'b0, div_q}) : rem_q;

   always_comb begin
      rem_d = rem_q;
      div_d = div_q;
      q_d   = q_q;
      cnt_d = cnt_q;
      if (load_i) begin
         rem_d = {1'b0, a_mant_i};
         div_d = b_mant_i;
         q_d   = '0;
         cnt_d = '0;
      end else if (step_i) begin
         rem_d = rem_sub << 1;
         q_d   = {q_q[QW-2:0], ge};
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_q <= '0;
         div_q <= '0;
         q_q   <= '0;
         cnt_q <= '0;
      end else begin
         rem_q <= rem_d;
         div_q <= div_d;
         q_q   <= q_d;
         cnt_q <= cnt_d;
      end
   end

   assign done_o = step_i && (cnt_q == LAST);
   assign q_o    = q_q;
   assign rem_o  = rem_q;

endmodule

// File: rtl/fp_div_seq.sv
// rtl/fp_div_seq.sv - multi-cycle IEEE-754-style divider with RNE and exception flags
// FSM handles classification, exponent, normalisation and rounding around the mantissa iterator.
module fp_div_seq
   import fp_div_pkg::*;
#(
   parameter int EXP_W  = 8,
   parameter int MANT_W = 23,
   parameter int BIAS   = 2**(EXP_W-1)-1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start_i,
   input  logic [EXP_W+MANT_W:0]   data_iA,
   input  logic [EXP_W+MANT_W:0]   data_iB,
   output logic                    ready_o,
   output logic                    valid_o,
   output logic [EXP_W+MANT_W:0]   data_o,
   output logic                    invalid_o,
   output logic                    divzero_o,
   output logic                    overflow_o,
   output logic                    underflow_o
);

   localparam int W  = 1 + EXP_W + MANT_W;
   localparam int EW = EXP_W + 2;
   localparam int QW = MANT_W + 4;
   localparam logic [MAX_W-1:0]     QNAN_FULL = fp_qnan(EXP_W, MANT_W);
   localparam logic [W-1:0]         QNAN      = QNAN_FULL[W-1:0];
   localparam logic signed [EW-1:0] BIAS_S    = EW'(BIAS);
   localparam logic signed [EW-1:0] E_ONE     = EW'(1);
   localparam logic signed [EW-1:0] E_MAX     = $signed({2'b00, {EXP_W{1'b1}}});

   state_e                state_q, state_d;
   op_class_e             a_cls_q, a_cls_d, b_cls_q, b_cls_d;
   logic                  sign_q, sign_d;
   logic signed [EW-1:0]  e_q, e_d;
   logic [MANT_W-1:0]     frac_q, frac_d;
   logic                  grd_q, grd_d, rnd_q, rnd_d, stk_q, stk_d;
   logic [W-1:0]          data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  invalid_q, invalid_d, divzero_q, divzero_d;
   logic                  overflow_q, overflow_d, underflow_q, underflow_d;

   op_class_e             cls_a, cls_b;
   logic                  iter_load, iter_step, iter_done;
   logic [QW-1:0]         iter_q;
   logic [MANT_W+1:0]     iter_rem;
   logic                  round_up;
   logic [MANT_W:0]       frac_r;
   logic signed [EW-1:0]  e_r;
   logic [W-1:0]          inf_res, zero_res;

   assign cls_a = fp_classify(64'(data_iA[W-2:MANT_W]), MAX_W'(data_iA[MANT_W-1:0]), EXP_W);
   assign cls_b = fp_classify(64'(data_iB[W-2:MANT_W]), MAX_W'(data_iB[MANT_W-1:0]), EXP_W);

   fp_mant_div_iter #(.MANT_W(MANT_W)) u_iter (
      .clk      (clk),
      .rst      (rst),
      .load_i   (iter_load),
      .step_i   (iter_step),
      .a_mant_i ({1'b1, data_iA[MANT_W-1:0]}),
      .b_mant_i ({1'b1, data_iB[MANT_W-1:0]}),
      .done_o   (iter_done),
      .q_o      (iter_q),
      .rem_o    (iter_rem)
   );

   // The hidden bit is implicit after NORM, so a fraction carry-out means mantissa 2.0.
   assign round_up = grd_q & (rnd_q | stk_q | frac_q[0]);
   assign frac_r   = {1'b0, frac_q} + {{MANT_W{1'b0}}, round_up};
   assign e_r      = e_q + $signed({{(EW-1){1'b0}}, frac_r[MANT_W]});
   assign inf_res  = {sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
   assign zero_res = {sign_q, {(W-1){1'b0}}};

   always_comb begin
      state_d     = state_q;
      a_cls_d     = a_cls_q;
      b_cls_d     = b_cls_q;
      sign_d      = sign_q;
      e_d         = e_q;
      frac_d      = frac_q;
      grd_d       = grd_q;
      rnd_d       = rnd_q;
      stk_d       = stk_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      invalid_d   = invalid_q;
      divzero_d   = divzero_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      iter_load   = 1'b0;
      iter_step   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               sign_d      = data_iA[W-1] ^ data_iB[W-1];
               a_cls_d     = cls_a;
               b_cls_d     = cls_b;
               e_d         = $signed({2'b00, data_iA[W-2:MANT_W]})
                           - $signed({2'b00, data_iB[W-2:MANT_W]}) + BIAS_S;
               invalid_d   = 1'b0;
               divzero_d   = 1'b0;
               overflow_d  = 1'b0;
               underflow_d = 1'b0;
               if (cls_a != CLS_NORMAL || cls_b != CLS_NORMAL) begin
                  state_d = S_SPECIAL;
               end else begin
                  iter_load = 1'b1;
                  state_d   = S_DIV;
               end
            end
         end
         S_SPECIAL: begin
            valid_d = 1'b1;
            state_d = S_IDLE;
            if (a_cls_q == CLS_NAN || b_cls_q == CLS_NAN ||
                (a_cls_q == CLS_ZERO && b_cls_q == CLS_ZERO) ||
                (a_cls_q == CLS_INF && b_cls_q == CLS_INF)) begin
               data_d    = QNAN;
               invalid_d = 1'b1;
            end else if (b_cls_q == CLS_ZERO) begin
               data_d    = inf_res;
               divzero_d = (a_cls_q == CLS_NORMAL);
            end else if (a_cls_q == CLS_INF) begin
               data_d = inf_res;
            end else begin
               data_d = zero_res;
            end
         end
         S_DIV: begin
            iter_step = 1'b1;
            if (iter_done) begin
               state_d = S_NORM;
            end
         end
         S_NORM: begin
            state_d = S_ROUND;
            if (iter_q[QW-1]) begin
               frac_d = iter_q[QW-2:3];
               grd_d  = iter_q[2];
               rnd_d  = iter_q[1];
               stk_d  = iter_q[0] | (|iter_rem);
            end else begin
               frac_d = iter_q[QW-3:2];
               grd_d  = iter_q[1];
               rnd_d  = iter_q[0];
               stk_d  = |iter_rem;
               e_d    = e_q - E_ONE;
            end
         end
         S_ROUND: begin
            valid_d = 1'b1;
            state_d = S_IDLE;
            if (!e_r[EW-1] && e_r >= E_MAX) begin
               data_d     = inf_res;
               overflow_d = 1'b1;
            end else if (e_r[EW-1] || e_r == '0) begin
               data_d      = zero_res;
               underflow_d = 1'b1;
            end else begin
               data_d = {sign_q, e_r[EXP_W-1:0], frac_r[MANT_W-1:0]};
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         a_cls_q     <= CLS_ZERO;
         b_cls_q     <= CLS_ZERO;
         sign_q      <= 1'b0;
         e_q         <= '0;
         frac_q      <= '0;
         grd_q       <= 1'b0;
         rnd_q       <= 1'b0;
         stk_q       <= 1'b0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         invalid_q   <= 1'b0;
         divzero_q   <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_cls_q     <= a_cls_d;
         b_cls_q     <= b_cls_d;
         sign_q      <= sign_d;
         e_q         <= e_d;
         frac_q      <= frac_d;
         grd_q       <= grd_d;
         rnd_q       <= rnd_d;
         stk_q       <= stk_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         invalid_q   <= invalid_d;
         divzero_q   <= divzero_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign ready_o     = (state_q == S_IDLE);
   assign valid_o     = valid_q;
   assign data_o      = data_q;
   assign invalid_o   = invalid_q;
   assign divzero_o   = divzero_q;
   assign overflow_o  = overflow_q;
   assign underflow_o = underflow_q;

endmodule
